// File: rtl/updown_counter_pkg.sv
// Shared definitions for the modulo up/down counter: mode encoding and the
// effective-step clamp used by the top level.
package updown_counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Step is limited to max_value, except that a nonzero step with max_value=0
  // becomes 1. This lets the single-value range still produce a wrap/saturate
  // pulse through the normal arithmetic path.
  function automatic logic [31:0] clampStep(input logic [31:0] stepIn,
                                            input logic [31:0] maxIn);
    logic [31:0] ceiling;
    ceiling = (maxIn == 32'd0) ? 32'd1 : maxIn;
    return (stepIn < ceiling) ? stepIn : ceiling;
  endfunction

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count calculation for one enabled counter cycle, using
// WIDTH+1 bit arithmetic so limit crossings are detected without truncation.
module updown_next_calc
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] max_value,
  input  logic             up_down,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_event,
  output logic             udf_event
);

  logic [WIDTH:0]   w_cnt;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_max;
  logic [WIDTH:0]   w_range;
  logic [WIDTH:0]   w_upSum;
  logic [WIDTH-1:0] w_upWrap;
  logic [WIDTH-1:0] w_dnDiff;
  logic [WIDTH-1:0] w_dnWrap;

  assign w_cnt    = {1'b0, count};
  assign w_s      = {1'b0, s};
  assign w_max    = {1'b0, max_value};
  assign w_range  = w_max + {{WIDTH{1'b0}}, 1'b1};
  assign w_upSum  = w_cnt + w_s;
  assign w_upWrap = WIDTH'(w_upSum - w_range);
  assign w_dnDiff = WIDTH'(w_cnt - w_s);
  assign w_dnWrap = WIDTH'(w_cnt + w_range - w_s);

  // An out-of-range count (max_value lowered) snaps to the limit silently.
  always_comb begin
    next_count = count;
    ovf_event  = 1'b0;
    udf_event  = 1'b0;
    if (w_cnt > w_max) begin
      next_count = max_value;
    end else if (w_s == '0) begin
      next_count = count;
    end else if (up_down) begin
      if (w_upSum > w_max) begin
        ovf_event  = 1'b1;
        next_count = (mode == MODE_SAT) ? max_value : w_upWrap;
      end else begin
        next_count = w_upSum[WIDTH-1:0];
      end
    end else begin
      if (w_s > w_cnt) begin
        udf_event  = 1'b1;
        next_count = (mode == MODE_SAT) ? '0 : w_dnWrap;
      end else begin
        next_count = w_dnDiff;
      end
    end
  end

endmodule

// File: rtl/modulo_updown_counter.sv
// Programmable-modulus up/down counter: holds the count, pulse and sticky
// flag registers and applies the rst > load > enable > hold priority.
module modulo_updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int STEP_W      = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_down,
  input  logic              mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_value,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  output logic              at_max,
  output logic              at_zero,
  output logic              sticky_ovf,
  output logic              sticky_udf
);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;
  logic             r_stickyOvf;
  logic             r_stickyUdf;

  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_ovfEvent;
  logic             w_udfEvent;
  logic             w_setOvf;
  logic             w_setUdf;
  logic [WIDTH-1:0] w_loadClamped;

  assign w_step        = WIDTH'(clampStep(32'(step), 32'(max_value)));
  assign w_loadClamped = (load_value > max_value) ? max_value : load_value;
  assign w_setOvf      = ~load & enable & w_ovfEvent;
  assign w_setUdf      = ~load & enable & w_udfEvent;

  updown_next_calc #(
    .WIDTH(WIDTH)
  ) u_nextCalc (
    .count      (r_count),
    .s          (w_step),
    .max_value  (max_value),
    .up_down    (up_down),
    .mode       (mode),
    .next_count (w_next),
    .ovf_event  (w_ovfEvent),
    .udf_event  (w_udfEvent)
  );

  // Sticky flags rise on the same edge as their pulse; a new event beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= WIDTH'(RESET_VALUE);
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_stickyOvf <= 1'b0;
      r_stickyUdf <= 1'b0;
    end else begin
      r_ovf       <= w_setOvf;
      r_udf       <= w_setUdf;
      r_stickyOvf <= w_setOvf | (r_stickyOvf & ~clear_flags);
      r_stickyUdf <= w_setUdf | (r_stickyUdf & ~clear_flags);
      if (load) begin
        r_count <= w_loadClamped;
      end else if (enable) begin
        r_count <= w_next;
      end
    end
  end

  assign count      = r_count;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;
  assign sticky_ovf = r_stickyOvf;
  assign sticky_udf = r_stickyUdf;
  assign at_max     = (r_count == max_value);
  assign at_zero    = (r_count == '0);

endmodule

// File: tb/tb_modulo_updown_counter.sv
// Scoreboard bench: stimulus pushes expected post-edge state from an integer
// reference model; a monitor pops and compares one entry after every edge.
module tb_modulo_updown_counter;

  localparam int WIDTH       = 8;
  localparam int STEP_W      = 4;
  localparam int RESET_VALUE = 0;

  logic              clk = 1'b0;
  logic              rst, enable, up_down, mode, load, clear_flags;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  max_value, load_value, count;
  logic              overflow, underflow, at_max, at_zero, sticky_ovf, sticky_udf;

  typedef struct {
    int count;
    bit ovf;
    bit udf;
    bit sov;
    bit sud;
    bit atMax;
    bit atZero;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   stimDone    = 1'b0;
  int   mCount      = 0;
  bit   mSov        = 1'b0;
  bit   mSud        = 1'b0;

  always #5 clk = ~clk;

  modulo_updown_counter #(
    .WIDTH       (WIDTH),
    .STEP_W      (STEP_W),
    .RESET_VALUE (RESET_VALUE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .up_down     (up_down),
    .mode        (mode),
    .step        (step),
    .max_value   (max_value),
    .load        (load),
    .load_value  (load_value),
    .clear_flags (clear_flags),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .at_max      (at_max),
    .at_zero     (at_zero),
    .sticky_ovf  (sticky_ovf),
    .sticky_udf  (sticky_udf)
  );

  task automatic checkOutput(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the reference model, queues the result.
  task automatic applyStimulus(input bit iRst, input bit iEn, input bit iUp,
                               input bit iMode, input int iStep, input int iMax,
                               input bit iLoad, input int iLv, input bit iClr);
    exp_t e;
    int   s;
    rst         = iRst;
    enable      = iEn;
    up_down     = iUp;
    mode        = iMode;
    step        = STEP_W'(iStep);
    max_value   = WIDTH'(iMax);
    load        = iLoad;
    load_value  = WIDTH'(iLv);
    clear_flags = iClr;
    e.ovf = 1'b0;
    e.udf = 1'b0;
    if (iRst) begin
      mCount = RESET_VALUE;
      mSov   = 1'b0;
      mSud   = 1'b0;
    end else begin
      if (iLoad) begin
        mCount = (iLv < iMax) ? iLv : iMax;
      end else if (iEn) begin
        s = (iStep < iMax) ? iStep : iMax;
        if (mCount > iMax) begin
          mCount = iMax;
        end else if (iMax == 0) begin
          if (iStep != 0) begin
            if (iUp) e.ovf = 1'b1;
            else     e.udf = 1'b1;
          end
        end else if (s == 0) begin
          mCount = mCount;
        end else if (iUp) begin
          if (mCount + s > iMax) begin
            e.ovf  = 1'b1;
            mCount = iMode ? iMax : (mCount + s) % (iMax + 1);
          end else begin
            mCount = mCount + s;
          end
        end else begin
          if (s > mCount) begin
            e.udf  = 1'b1;
            mCount = iMode ? 0 : (mCount - s + iMax + 1) % (iMax + 1);
          end else begin
            mCount = mCount - s;
          end
        end
      end
      mSov = e.ovf | (mSov & !iClr);
      mSud = e.udf | (mSud & !iClr);
    end
    e.count  = mCount;
    e.sov    = mSov;
    e.sud    = mSud;
    e.atMax  = (mCount == iMax);
    e.atZero = (mCount == 0);
    expQ.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count",      int'(count),      e.count);
        checkOutput("overflow",   int'(overflow),   int'(e.ovf));
        checkOutput("underflow",  int'(underflow),  int'(e.udf));
        checkOutput("sticky_ovf", int'(sticky_ovf), int'(e.sov));
        checkOutput("sticky_udf", int'(sticky_udf), int'(e.sud));
        checkOutput("at_max",     int'(at_max),     int'(e.atMax));
        checkOutput("at_zero",    int'(at_zero),    int'(e.atZero));
      end else if (!stimDone) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL scoreboard_underrun: got 0 entries expected 1 at %0t", $time);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "[TB] bench timed out");
  end

  initial begin : stimulus
    int curMax;
    // Basic wrap up through modulus 10
    repeat (3) applyStimulus(1, 0, 1, 0, 1, 9, 0, 0, 0);
    repeat (11) applyStimulus(0, 1, 1, 0, 1, 9, 0, 0, 0);
    // Saturate up, repeated pulse at the ceiling, then idle
    applyStimulus(0, 0, 1, 1, 3, 200, 1, 198, 0);
    repeat (2) applyStimulus(0, 1, 1, 1, 3, 200, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 3, 200, 0, 0, 0);
    // Wrap down with step 3, then zero step holds
    applyStimulus(0, 0, 0, 0, 3, 9, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 3, 9, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 9, 0, 0, 0);
    // Load clamp beats enable, then lowered max_value snaps count
    applyStimulus(0, 1, 1, 0, 1, 100, 1, 250, 0);
    applyStimulus(0, 1, 1, 0, 1, 50, 0, 0, 0);
    // Overflow coinciding with clear keeps sticky set; clear alone drops it
    applyStimulus(0, 0, 1, 0, 1, 9, 1, 9, 0);
    applyStimulus(0, 1, 1, 0, 1, 9, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 1, 9, 0, 0, 1);
    // Reset wins over simultaneous load and enable
    applyStimulus(0, 1, 0, 0, 5, 9, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 9, 1, 5, 0);
    applyStimulus(1, 1, 1, 0, 1, 9, 1, 7, 0);
    applyStimulus(0, 0, 1, 0, 1, 9, 0, 0, 0);
    // Single-value range: pulses but count stays 0
    applyStimulus(0, 1, 1, 0, 5, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 5, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 255, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 15, 255, 1, 250, 0);
    applyStimulus(0, 1, 1, 0, 15, 255, 0, 0, 0);
    // Randomised traffic with occasional max_value changes
    curMax = 12;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        curMax = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 20));
      applyStimulus($urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 15)),
                    curMax,
                    $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 255)),
                    $urandom_range(0, 7) == 0);
    end
    stimDone = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modulo_updown_counter.md
Name: modulo_updown_counter

Overview:
Parametrised up/down counter with a runtime-programmable modulus, a configurable step size, a selectable wrap or saturate mode, synchronous load, and registered overflow/underflow pulses with sticky flags. It supersedes the fixed 4-bit up/down counter for timer, pointer and credit tracking in the datapath. The count range is 0..max_value. Flags allow software polling without missing single-cycle events.

Parameters:
WIDTH, 8, count/limit width in bits (>=2)
STEP_W, 4, step input width in bits (1..WIDTH)
RESET_VALUE, 0, count value after reset (must be <= all legal max_value)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
enable  input  1  advance count this cycle
up_down  input  1  1 = count up, 0 = count down
mode  input  1  0 = wrap (modulo max_value+1), 1 = saturate
step  input  STEP_W  increment/decrement amount
max_value  input  WIDTH  upper bound of the count range (inclusive)
load  input  1  synchronous load strobe
load_value  input  WIDTH  value for load
clear_flags  input  1  clears sticky flags
count  output  WIDTH  registered count
overflow  output  1  registered 1-cycle pulse on upward wrap/saturation
underflow  output  1  registered 1-cycle pulse on downward wrap/saturation
at_max  output  1  combinational: count == max_value
at_zero  output  1  combinational: count == 0
sticky_ovf  output  1  latched overflow
sticky_udf  output  1  latched underflow

Behaviour:
- Reset: synchronous active-high reset on clk. It forces count=RESET_VALUE and overflow=underflow=sticky_ovf=sticky_udf=0. Reset overrides every other input in the same cycle.
- Priority per cycle: rst > load > enable > hold.
- load: count <= min(load_value, max_value). No pulse is raised. Sticky flags are unaffected.
- Hold cases: with enable=0 and no load, count holds and overflow/underflow are 0.
- Effective step: s = min(zero-extended step, max_value). Internal arithmetic is WIDTH+1 bits, so no silent truncation occurs.
- Zero step: when s=0, count holds and no pulse is raised.
- Out-of-range count: if count > max_value on an enabled cycle (max_value was lowered), count <= max_value regardless of direction. No pulse is raised.
- Up, no limit crossed: when count+s <= max_value, count <= count+s.
- Up, limit crossed: when count+s > max_value:
  - Wrap mode: count <= count+s-(max_value+1).
  - Saturate mode: count <= max_value.
  - In both modes overflow=1 the following cycle. In saturate mode this repeats on every enabled up cycle while the count sits at max_value.
- Down, no limit crossed: when s <= count, count <= count-s.
- Down, limit crossed: when s > count:
  - Wrap mode: count <= count+(max_value+1)-s.
  - Saturate mode: count <= 0.
  - In both modes underflow=1.
- Latency: count, overflow and underflow all update on the same clock edge; the pulse is coincident with the new count.
- Sticky flags:
  - sticky_ovf sets on any cycle where overflow is registered high.
  - clear_flags clears both sticky flags, but a simultaneous set wins.
  - The same rules apply to sticky_udf.
- max_value=0: count stays 0.
  - Any nonzero-step enabled cycle pulses overflow (up) or underflow (down).
  - Wrap and saturate modes behave identically here.
- at_max and at_zero are derived from the registered count and the current max_value; there is no extra latency.
- mode, step and max_value are sampled every cycle. Changing them mid-count is legal and takes effect on the next edge.

Decomposition:
- Shared package updown_counter_pkg holds:
  - the mode encoding constants MODE_WRAP=1'b0 and MODE_SAT=1'b1;
  - a function computing the effective step clamp.
- One combinational sub-module, updown_next_calc, takes (count, s, max_value, up_down, mode) and returns next_count, ovf_event and udf_event.
- The top level holds the registers, the priority logic and the sticky flags.

Test Plan:
1. Basic wrap up: WIDTH=8, max_value=9, mode=0, step=1, up=1. Hold rst=1 for 3 cycles, then enable. Count goes 0,1,..,9,0; overflow pulses exactly once, coincident with count=0; sticky_ovf=1 afterwards.
2. Saturate up: max_value=200, load 198, mode=1, step=3, up. Count=200 with overflow=1; next enabled cycle count=200 and overflow=1 again; with enable=0, overflow=0.
3. Wrap down with step: max_value=9, load 1, step=3, down, mode=0. Count=8 with underflow=1. Then step=0 → count holds at 8, underflow=0.
4. Load clamp and priority: max_value=100, load=1, load_value=250, enable=1, up → count=100, no overflow. Then max_value changed to 50 with enable=1 → count=50, no pulse.
5. Sticky flags: force an overflow event in the same cycle as clear_flags=1 → sticky_ovf stays 1. Next cycle clear_flags=1 alone → sticky_ovf=0 and sticky_udf=0.
6. Reset mid-operation: count=5, assert rst together with load=1 and enable=1 → next cycle count=RESET_VALUE (0) and all flags 0.
